systolic_seq_ctrl: RTL and testbench
====================================

SYSTOLIC_SEQ_CTRL -- requirements
Module: systolic_seq_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum RUN cycles to wait for arr_done.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  host operand beat valid.
REQ-005 SHALL have port in_ready  output  1  controller accepts operand beat.
REQ-006 SHALL have port in_data  input  8  operand byte.
REQ-007 SHALL have port out_valid  output  1  result beat valid.
REQ-008 SHALL have port out_ready  input  1  host accepts result beat.
REQ-009 SHALL have port out_data  output  16  result element.
REQ-010 SHALL have port out_last  output  1  marks 9th result beat.
REQ-011 SHALL have ports busy / err  output  1 each: not idle / sticky timeout flag.
REQ-012 SHALL have port arr_clr  output  1  clear pulse to systolic array reset.
REQ-013 SHALL have port arr_start  output  1  load pulse to array.
REQ-014 SHALL have ports arr_a / arr_b  output  72 each: element k (row-major) at bits [8k+7:8k].
REQ-015 SHALL have ports arr_c  input  144 (element k at [16k+15:16k]) and arr_done  input  1.

Function
REQ-016 SHALL implement states IDLE, LOAD, CLR, START, RUN, OUT.
REQ-017 in_ready SHALL be 1 only in IDLE and LOAD; a beat transfers when in_valid && in_ready.
REQ-018 Beats 0-8 SHALL fill A row-major, beats 9-17 B row-major; first beat in IDLE moves to LOAD and clears err.
REQ-019 On beat 17 accepted: LOAD -> CLR; arr_clr high exactly one cycle in CLR; CLR -> START.
REQ-020 arr_start high exactly one cycle in START; START -> RUN; arr_a/arr_b stable from CLR until leaving OUT.
REQ-021 RUN: first cycle with arr_done=1 SHALL latch arr_c into result registers and go to OUT.
REQ-022 RUN cycle count reaching TIMEOUT with arr_done=0 SHALL set err, latch arr_c, go to OUT.
REQ-023 OUT: out_valid=1, out_data = result element k (k=0..8); k advances only on out_valid && out_ready; out_data/out_valid held under backpressure.
REQ-024 out_last=1 when k=8; on that transfer OUT -> IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 Results SHALL be passed unmodified (16-bit, array truncation preserved); no arithmetic in controller.

Reset
REQ-027 rst SHALL force IDLE, beat and cycle counters 0, all operand/result registers 0, at any time including mid-LOAD/RUN/OUT.
REQ-028 Reset outputs: in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0, err=0, arr_clr=0, arr_start=0, arr_a=arr_b=0.

Configuration
REQ-029 Macro SYSTOLIC_SEQ_CTRL_PERF_EN defined: extra output perf_cycles[15:0] = RUN cycles of last job, updated at RUN exit, reset 0.
REQ-030 Macro undefined: perf_cycles port and its counter absent; all other behaviour identical.

Structure
REQ-031 Package systolic_pkg SHALL hold state enum, N=3, DW=8, CW=16, OPERAND_BEATS=18, RESULT_BEATS=9.
REQ-032 No sub-module; the systolic array is instantiated by the parent, connected through arr_* ports.

Verification
REQ-033 A=identity, B=1..9 row-major, array model -> out_data 1,2,...,9, out_last on 9th, err=0.
REQ-034 A=2*identity, B=all 1, out_ready toggling 1/0 each cycle -> nine beats of 2, each held while out_ready=0.
REQ-035 Two back-to-back jobs (job 2 A=identity, B=all 3) -> arr_clr pulses once per job; job 2 outputs all 3 (no accumulation).
REQ-036 arr_done tied 0 -> OUT entered after 15 RUN cycles, err=1, nine beats emitted; next job's first beat clears err.
REQ-037 rst asserted after 5 LOAD beats -> IDLE, in_ready=1, busy=0; subsequent 18 beats complete a correct job.
REQ-038 With SYSTOLIC_SEQ_CTRL_PERF_EN and arr_done at 8th RUN cycle -> perf_cycles=8.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and sizing for the systolic array sequencer.
package systolic_pkg;

  localparam int N             = 3;
  localparam int DW            = 8;
  localparam int CW            = 16;
  localparam int OPERAND_BEATS = 18;
  localparam int RESULT_BEATS  = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLR,
    S_START,
    S_RUN,
    S_OUT
  } state_t;

endpackage

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a 3x3 systolic matrix multiplier: streams 18 operand bytes
// in (A then B, row-major), clears and starts the array, waits for done or
// timeout, then streams the nine 16-bit results out.
// Optional build macro SYSTOLIC_SEQ_CTRL_PERF_EN adds perf_cycles, the RUN
// cycle count of the most recent job.
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DW-1:0]              in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CW-1:0]              out_data,
  output logic                       out_last,
  output logic                       busy,
  output logic                       err,
  output logic                       arr_clr,
  output logic                       arr_start,
  output logic [RESULT_BEATS*DW-1:0] arr_a,
  output logic [RESULT_BEATS*DW-1:0] arr_b,
  input  logic [RESULT_BEATS*CW-1:0] arr_c,
  input  logic                       arr_done
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
  ,
  output logic [15:0]                perf_cycles
`endif
);

  state_t state_q, state_d;

  logic [4:0]                           beat_q;
  logic [15:0]                          run_q;
  logic [3:0]                           k_q;
  logic [RESULT_BEATS-1:0][DW-1:0]      a_q, b_q;
  logic [RESULT_BEATS-1:0][CW-1:0]      res_q;
  logic                                 err_q;

  logic       in_fire, out_fire, last_beat, last_res, run_exit;
  logic [4:0] b_idx;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_beat = (beat_q == 5'(OPERAND_BEATS - 1));
  assign last_res  = (k_q == 4'(RESULT_BEATS - 1));
  // Leave RUN on the first done cycle, or once the TIMEOUT-th cycle elapses.
  assign run_exit  = arr_done || (run_q == 16'(TIMEOUT - 1));
  assign b_idx     = beat_q - 5'd9;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_fire) state_d = S_LOAD;
      S_LOAD:  if (in_fire && last_beat) state_d = S_CLR;
      S_CLR:   state_d = S_START;
      S_START: state_d = S_RUN;
      S_RUN:   if (run_exit) state_d = S_OUT;
      S_OUT:   if (out_fire && last_res) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; out_data is forced to zero outside OUT.
  always_comb begin
    in_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
    busy      = (state_q != S_IDLE);
    arr_clr   = (state_q == S_CLR);
    arr_start = (state_q == S_START);
    out_valid = (state_q == S_OUT);
    out_last  = (state_q == S_OUT) && last_res;
    out_data  = (state_q == S_OUT) ? res_q[k_q] : '0;
  end

  // Operand capture, run counting, result latch and output index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= '0;
      run_q  <= '0;
      k_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (in_fire) begin
        if (beat_q < 5'd9) a_q[beat_q[3:0]] <= in_data;
        else               b_q[b_idx[3:0]]  <= in_data;
        beat_q <= last_beat ? 5'd0 : beat_q + 5'd1;
        // A new job starts with a clean error flag.
        if (state_q == S_IDLE) err_q <= 1'b0;
      end
      if (state_q == S_RUN) begin
        if (run_exit) begin
          res_q <= arr_c;
          run_q <= '0;
          if (!arr_done) err_q <= 1'b1;
        end else begin
          run_q <= run_q + 16'd1;
        end
      end
      if (out_fire) k_q <= last_res ? 4'd0 : k_q + 4'd1;
    end
  end

`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
  // RUN length of the last job, captured as RUN is left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                perf_cycles <= '0;
    else if (state_q == S_RUN && run_exit)  perf_cycles <= run_q + 16'd1;
  end
`endif

  assign arr_a = a_q;
  assign arr_b = b_q;
  assign err   = err_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl with a behavioural 3x3 array model.
module tb_systolic_seq_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [7:0]   in_data;
  logic         out_valid, out_ready, out_last;
  logic [15:0]  out_data;
  logic         busy, err, arr_clr, arr_start, arr_done;
  logic [71:0]  arr_a, arr_b;
  logic [143:0] arr_c;
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
  logic [15:0]  perf_cycles;
`endif

  always #5 clk = ~clk;

  systolic_seq_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .err(err),
    .arr_clr(arr_clr), .arr_start(arr_start),
    .arr_a(arr_a), .arr_b(arr_b), .arr_c(arr_c),
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
    .perf_cycles(perf_cycles),
`endif
    .arr_done(arr_done)
  );

  // Array model: C = A*B truncated to 16 bits, done on the done_at-th cycle
  // after the start pulse (done_at = 0 means never done).
  logic [8:0][7:0]  ma, mb;
  logic [8:0][15:0] cm;
  logic [7:0]       arr_t;
  int               done_at;
  assign ma = arr_a;
  assign mb = arr_b;
  always_comb begin
    cm = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        for (int m = 0; m < 3; m++)
          cm[i*3+j] = cm[i*3+j] + 16'(16'(ma[i*3+m]) * 16'(mb[m*3+j]));
  end
  assign arr_c    = cm;
  assign arr_done = (done_at != 0) && (arr_t == done_at[7:0]);
  always @(posedge clk) begin
    if (arr_clr)                           arr_t <= 8'd0;
    else if (arr_start)                    arr_t <= 8'd1;
    else if (arr_t != 0 && arr_t != 8'hff) arr_t <= arr_t + 8'd1;
  end

  // Event monitors: pulse counters and RUN-cycle length of the current job.
  int clr_cnt = 0, start_cnt = 0, runc = 0;
  always @(posedge clk) begin
    if (arr_clr)   clr_cnt <= clr_cnt + 1;
    if (arr_start) begin
      start_cnt <= start_cnt + 1;
      runc      <= 0;
    end else if (busy && !in_ready && !arr_clr && !out_valid) begin
      runc <= runc + 1;
    end
  end

  typedef struct {
    logic [8:0][7:0]  a;
    logic [8:0][7:0]  b;
    int               done_at;
    bit               toggle;
    logic [8:0][15:0] exp;
    bit               exp_err;
    int               exp_runc;
  } job_t;

  job_t jobs[5];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic load_beats(input int j, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("in_ready_load", in_ready, 1'b1);
      if (i == 1) chk("err_cleared", err, 1'b0);
      in_valid = 1'b1;
      in_data  = (i < 9) ? jobs[j].a[i] : jobs[j].b[i-9];
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(input int j);
    int k   = 0;
    int cyc = 0;
    while (k < 9 && cyc < 200) begin
      @(negedge clk);
      if (out_valid) begin
        chk("out_data", out_data, jobs[j].exp[k]);
        chk("out_last", out_last, (k == 8));
        if (k == 0) chk("err_at_out", err, jobs[j].exp_err);
        out_ready = jobs[j].toggle ? (cyc % 2 == 1) : 1'b1;
        if (out_ready) k++;
      end else begin
        out_ready = 1'b1;
      end
      cyc++;
    end
    chk("result_beats", k, 9);
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_in_ready", in_ready, 1'b1);
    chk("idle_out_valid", out_valid, 1'b0);
  endtask

  task automatic run_job(input int j);
    int c0 = clr_cnt;
    int s0 = start_cnt;
    done_at = jobs[j].done_at;
    load_beats(j, 18);
    collect(j);
    chk("clr_pulses", clr_cnt - c0, 1);
    chk("start_pulses", start_cnt - s0, 1);
    chk("run_cycles", runc, jobs[j].exp_runc);
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
    chk("perf_cycles", perf_cycles, jobs[j].exp_runc);
`endif
  endtask

  initial begin
    // Job table: identity*1..9, 2I*ones under backpressure, I*3s back to back,
    // timeout with I*7s, then 255s*255s (truncated to 64003) finishing at cycle 8.
    for (int k = 0; k < 9; k++) begin
      jobs[0].a[k] = (k % 4 == 0) ? 8'd1 : 8'd0;
      jobs[0].b[k] = 8'(k + 1);
      jobs[0].exp[k] = 16'(k + 1);
      jobs[1].a[k] = (k % 4 == 0) ? 8'd2 : 8'd0;
      jobs[1].b[k] = 8'd1;
      jobs[1].exp[k] = 16'd2;
      jobs[2].a[k] = (k % 4 == 0) ? 8'd1 : 8'd0;
      jobs[2].b[k] = 8'd3;
      jobs[2].exp[k] = 16'd3;
      jobs[3].a[k] = (k % 4 == 0) ? 8'd1 : 8'd0;
      jobs[3].b[k] = 8'd7;
      jobs[3].exp[k] = 16'd7;
      jobs[4].a[k] = 8'd255;
      jobs[4].b[k] = 8'd255;
      jobs[4].exp[k] = 16'd64003;
    end
    jobs[0].done_at = 3; jobs[0].toggle = 0; jobs[0].exp_err = 0; jobs[0].exp_runc = 3;
    jobs[1].done_at = 4; jobs[1].toggle = 1; jobs[1].exp_err = 0; jobs[1].exp_runc = 4;
    jobs[2].done_at = 2; jobs[2].toggle = 0; jobs[2].exp_err = 0; jobs[2].exp_runc = 2;
    jobs[3].done_at = 0; jobs[3].toggle = 0; jobs[3].exp_err = 1; jobs[3].exp_runc = 15;
    jobs[4].done_at = 8; jobs[4].toggle = 0; jobs[4].exp_err = 0; jobs[4].exp_runc = 8;

    rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0; done_at = 0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_data", out_data, 16'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_arr_clr", arr_clr, 1'b0);
    chk("rst_arr_start", arr_start, 1'b0);
    chk("rst_arr_a", arr_a, 72'd0);
    chk("rst_arr_b", arr_b, 72'd0);
    rst = 1'b0;

    // Reset in the middle of LOAD discards the partial job.
    load_beats(0, 5);
    chk("midload_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("midload_rst_in_ready", in_ready, 1'b1);
    chk("midload_rst_busy", busy, 1'b0);
    chk("midload_rst_arr_a", arr_a, 72'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int j = 0; j < 5; j++) run_job(j);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
